// File: rtl/alu_arb_ctrl.sv
// -----------------------------------------------------------------------------
// alu_arb_ctrl
//
// Round-robin arbiter and sequencer for a shared combinational ALU.
// Two requesters present ALU operations over valid/ready handshakes. The
// granted operation's operands and select are registered into the ALU. One
// edge later the ALU result and flags are captured into a tagged, one-cycle
// response, and the architectural status register is updated.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   reqK_valid/ready/sel/a/b      requester K handshake and operation (K=0,1)
//   alu_a, alu_b, alu_sel         registered operands/select to the ALU
//   alu_result, alu_flags         combinational ALU outputs
//   rsp_valid/id/result/flags     one-cycle response pulse and its payload
//   rsp_wb                        result should be written back
//   rsp_err                       illegal opcode (only with the check enabled)
//   status                        flags of the last completed legal operation
//   busy                          an operation is in flight
//
// Build option:
//   ALU_ARB_ILLEGAL_CHK_EN  when defined, opcodes outside the legal set are
//                           still accepted, but never reach the ALU. They
//                           return rsp_err=1 with zero payload and leave
//                           status untouched. When undefined, every opcode
//                           passes through and rsp_err is always 0.
// -----------------------------------------------------------------------------
// state   | meaning
// --------+--------------------------------------------------------------------
// ST_IDLE | no operation in flight; grant and accept a request
// ST_EXEC | operands are on the ALU; capture result/flags at the next edge
// -----------------------------------------------------------------------------
module alu_arb_ctrl #(
    parameter int WIDTH  = 16,
    parameter int SEL_W  = 5,
    parameter int FLAG_W = 5
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [SEL_W-1:0]  req0_sel,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [SEL_W-1:0]  req1_sel,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,

    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic [FLAG_W-1:0] alu_flags,

    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [WIDTH-1:0]  rsp_result,
    output logic [FLAG_W-1:0] rsp_flags,
    output logic              rsp_wb,
    output logic              rsp_err,
    output logic [FLAG_W-1:0] status,
    output logic              busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] OP_BIT = SEL_W'(6);
    localparam logic [SEL_W-1:0] OP_CMP = SEL_W'(9);

`ifdef ALU_ARB_ILLEGAL_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    function automatic logic op_legal(input logic [SEL_W-1:0] s);
        case (s)
            SEL_W'(0), SEL_W'(1), SEL_W'(3), SEL_W'(4),
            SEL_W'(6), SEL_W'(7), SEL_W'(8), SEL_W'(9): op_legal = 1'b1;
            default:                                     op_legal = 1'b0;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic              last_gnt_q;
    logic              own_q;
    logic              err_q;
    logic [WIDTH-1:0]  alu_a_q, alu_b_q;
    logic [SEL_W-1:0]  alu_sel_q;
    logic              rsp_valid_q, rsp_id_q, rsp_wb_q, rsp_err_q;
    logic [WIDTH-1:0]  rsp_result_q;
    logic [FLAG_W-1:0] rsp_flags_q, status_q;

    logic              gnt0, gnt1, hs, hs_legal, op_wb;
    logic [SEL_W-1:0]  hs_sel;
    logic [WIDTH-1:0]  hs_a, hs_b;

    // Grant only in IDLE; on a tie the requester not served last wins.
    always_comb begin
        state_d = state_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0_valid && req1_valid) begin
                    gnt0 = last_gnt_q;
                    gnt1 = ~last_gnt_q;
                end else begin
                    gnt0 = req0_valid;
                    gnt1 = req1_valid;
                end
                if (gnt0 || gnt1) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A grant is always to a valid requester, so a grant is a handshake.
    assign hs       = gnt0 | gnt1;
    assign hs_sel   = gnt1 ? req1_sel : req0_sel;
    assign hs_a     = gnt1 ? req1_a   : req0_a;
    assign hs_b     = gnt1 ? req1_b   : req0_b;
    assign hs_legal = !CHK_EN || op_legal(hs_sel);

    // alu_sel_q still holds the in-flight opcode for legal operations; the
    // illegal case is forced to no writeback at capture time.
    assign op_wb = !((alu_sel_q == OP_CMP) || (alu_sel_q == OP_BIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_gnt_q   <= 1'b1;
            own_q        <= 1'b0;
            err_q        <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_wb_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            status_q     <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= 1'b0;
            if (hs) begin
                own_q      <= gnt1;
                last_gnt_q <= gnt1;
                err_q      <= ~hs_legal;
                if (hs_legal) begin
                    alu_a_q   <= hs_a;
                    alu_b_q   <= hs_b;
                    alu_sel_q <= hs_sel;
                end
            end
            if (state_q == ST_EXEC) begin
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= own_q;
                if (err_q) begin
                    rsp_result_q <= '0;
                    rsp_flags_q  <= '0;
                    rsp_wb_q     <= 1'b0;
                    rsp_err_q    <= 1'b1;
                end else begin
                    rsp_result_q <= alu_result;
                    rsp_flags_q  <= alu_flags;
                    rsp_wb_q     <= op_wb;
                    rsp_err_q    <= 1'b0;
                    status_q     <= alu_flags;
                end
            end
        end
    end

    // Readies are masked by reset so every output reads 0 while rst is high.
    assign req0_ready = gnt0 & ~rst;
    assign req1_ready = gnt1 & ~rst;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_wb     = rsp_wb_q;
    assign rsp_err    = rsp_err_q;
    assign status     = status_q;
    assign busy       = (state_q == ST_EXEC);

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Self-checking bench for alu_arb_ctrl: directed vector table, hand-written
// multi-cycle sequences, and a randomized run against a transaction model.
module tb_alu_arb_ctrl;

`ifdef ALU_ARB_ILLEGAL_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_sel = '0, req1_sel = '0;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [15:0] alu_a, alu_b, alu_result;
    logic [4:0]  alu_sel, alu_flags;
    logic        rsp_valid, rsp_id, rsp_wb, rsp_err, busy;
    logic [15:0] rsp_result;
    logic [4:0]  rsp_flags, status;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_arb_ctrl dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_wb(rsp_wb), .rsp_err(rsp_err),
        .status(status), .busy(busy)
    );

    // Behavioural ALU stub: returns {flags(c,v,n,z,p), result}.
    function automatic logic [20:0] alu_f(input logic [4:0] s, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] w;
        logic [15:0] r;
        logic c, v;
        w = '0; r = '0; c = 1'b0; v = 1'b0;
        case (s)
            5'b00000: begin
                w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16];
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            5'b00001, 5'b01001: begin
                w = {1'b0, a} - {1'b0, b}; r = w[15:0]; c = w[16];
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            5'b00011: r = a & b;
            5'b00100: r = a | b;
            5'b00110: r = a & b;
            5'b00111: r = a ^ b;
            5'b01000: r = ~a;
            default:  r = {a[7:0], b[7:0]};
        endcase
        return {c, v, r[15], (r == 16'h0), ^r, r};
    endfunction

    always_comb {alu_flags, alu_result} = alu_f(alu_sel, alu_a, alu_b);

    function automatic logic is_legal(input logic [4:0] s);
        return s inside {5'd0, 5'd1, 5'd3, 5'd4, 5'd6, 5'd7, 5'd8, 5'd9};
    endfunction

    function automatic logic is_wb(input logic [4:0] s);
        return !(s == 5'b01001 || s == 5'b00110);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive_req(input int id, input logic v, input logic [4:0] s,
                             input logic [15:0] a, input logic [15:0] b);
        if (id == 0) begin
            req0_valid = v; req0_sel = s; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_sel = s; req1_a = a; req1_b = b;
        end
    endtask

    // Bench-side view of what the ALU registers and status should hold.
    logic [4:0]  m_sel = '0, m_status = '0;
    logic [15:0] m_a = '0, m_b = '0;

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_req0_ready"}, req0_ready, 0);
        chk({pfx, "_req1_ready"}, req1_ready, 0);
        chk({pfx, "_alu_a"}, alu_a, 0);
        chk({pfx, "_alu_b"}, alu_b, 0);
        chk({pfx, "_alu_sel"}, alu_sel, 0);
        chk({pfx, "_rsp_valid"}, rsp_valid, 0);
        chk({pfx, "_rsp_id"}, rsp_id, 0);
        chk({pfx, "_rsp_result"}, rsp_result, 0);
        chk({pfx, "_rsp_flags"}, rsp_flags, 0);
        chk({pfx, "_rsp_wb"}, rsp_wb, 0);
        chk({pfx, "_rsp_err"}, rsp_err, 0);
        chk({pfx, "_status"}, status, 0);
        chk({pfx, "_busy"}, busy, 0);
    endtask

    // Single operation from an idle controller, checked cycle by cycle.
    task automatic run_op(input string pfx, input int id, input logic [4:0] s,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_res, input logic exp_wb);
        logic [20:0] fr;
        logic        ill;
        fr  = alu_f(s, a, b);
        ill = CHK && !is_legal(s);
        @(negedge clk);
        drive_req(id, 1'b1, s, a, b);
        #1;
        chk({pfx, "_rsp_idle"}, rsp_valid, 0);
        chk({pfx, "_ready"}, (id == 0) ? req0_ready : req1_ready, 1);
        chk({pfx, "_other_ready"}, (id == 0) ? req1_ready : req0_ready, 0);
        chk({pfx, "_busy_idle"}, busy, 0);
        @(negedge clk);
        drive_req(id, 1'b0, s, a, b);
        #1;
        if (!ill) begin
            m_sel = s; m_a = a; m_b = b;
        end
        chk({pfx, "_busy_exec"}, busy, 1);
        chk({pfx, "_ready_exec"}, {req0_ready, req1_ready}, 0);
        chk({pfx, "_rsp_exec"}, rsp_valid, 0);
        chk({pfx, "_alu_sel"}, alu_sel, m_sel);
        chk({pfx, "_alu_a"}, alu_a, m_a);
        chk({pfx, "_alu_b"}, alu_b, m_b);
        @(negedge clk);
        #1;
        chk({pfx, "_rsp_valid"}, rsp_valid, 1);
        chk({pfx, "_rsp_id"}, rsp_id, id);
        chk({pfx, "_rsp_err"}, rsp_err, ill);
        chk({pfx, "_rsp_result"}, rsp_result, ill ? 16'h0 : exp_res);
        chk({pfx, "_rsp_flags"}, rsp_flags, ill ? 5'h0 : fr[20:16]);
        chk({pfx, "_rsp_wb"}, rsp_wb, ill ? 1'b0 : exp_wb);
        if (!ill) m_status = fr[20:16];
        chk({pfx, "_status"}, status, m_status);
    endtask

    typedef struct {
        int          id;
        logic [4:0]  sel;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        wb;
    } vec_t;

    vec_t vecs[11];

    logic [4:0] legal_ops [8] = '{5'd0, 5'd1, 5'd3, 5'd4, 5'd6, 5'd7, 5'd8, 5'd9};

    initial begin
        logic        mv [2];
        logic [4:0]  qs [2];
        logic [15:0] qa [2];
        logic [15:0] qb [2];
        logic        mbusy, m_last, g0, g1, e_v, e_id, e_wb, e_err, ill;
        logic [4:0]  ps, e_flags;
        logic [15:0] pa, pb, e_res;
        logic [20:0] fr;
        int          own;

        vecs[0]  = '{0, 5'b00000, 16'd5,    16'd8,    16'd13,   1'b1};
        vecs[1]  = '{1, 5'b00001, 16'd5,    16'd8,    16'hFFFD, 1'b1};
        vecs[2]  = '{0, 5'b00011, 16'd5,    16'd8,    16'h0000, 1'b1};
        vecs[3]  = '{1, 5'b01001, 16'd10,   16'd10,   16'h0000, 1'b0};
        vecs[4]  = '{1, 5'b00110, 16'hF0F0, 16'h0F0F, 16'h0000, 1'b0};
        vecs[5]  = '{0, 5'b00100, 16'h1200, 16'h0034, 16'h1234, 1'b1};
        vecs[6]  = '{1, 5'b00010, 16'd5,    16'd8,    16'h0508, 1'b1};
        vecs[7]  = '{0, 5'b00111, 16'hFFFF, 16'h00FF, 16'hFF00, 1'b1};
        vecs[8]  = '{1, 5'b01000, 16'h00FF, 16'h0000, 16'hFF00, 1'b1};
        vecs[9]  = '{0, 5'b00000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
        vecs[10] = '{1, 5'b00000, 16'h1234, 16'h1111, 16'h2345, 1'b1};

        // Reset state
        #1 rst = 1'b1;
        #1 check_all_zero("rst_init");
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].id, vecs[i].sel, vecs[i].a,
                   vecs[i].b, vecs[i].res, vecs[i].wb);
        end

        // Asynchronous reset mid-cycle, with a request pending
        @(negedge clk);
        drive_req(0, 1'b1, 5'b00000, 16'd1, 16'd2);
        #2 rst = 1'b1;
        #1 check_all_zero("rst_async");
        @(negedge clk);
        drive_req(0, 1'b0, 5'b00000, 16'd0, 16'd0);
        rst = 1'b0;
        m_sel = '0; m_a = '0; m_b = '0; m_status = '0;

        // Tie from reset: req0 first, then strict alternation
        drive_req(0, 1'b1, 5'b00001, 16'd5, 16'd8);
        drive_req(1, 1'b1, 5'b00011, 16'd5, 16'd8);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("tie%0d_req0_ready", k), req0_ready, (k % 2 == 0));
            chk($sformatf("tie%0d_req1_ready", k), req1_ready, (k % 2 == 1));
            chk($sformatf("tie%0d_rsp_valid", k), rsp_valid, (k > 0));
            if (k > 0) begin
                chk($sformatf("tie%0d_rsp_id", k), rsp_id, (k - 1) % 2);
                chk($sformatf("tie%0d_rsp_result", k), rsp_result,
                    ((k - 1) % 2 == 0) ? 16'hFFFD : 16'h0000);
            end
            @(negedge clk);
            if (k == 7) begin
                drive_req(0, 1'b0, 5'b00001, 16'd5, 16'd8);
                drive_req(1, 1'b0, 5'b00011, 16'd5, 16'd8);
            end
            #1;
            chk($sformatf("tie%0d_busy", k), busy, 1);
            chk($sformatf("tie%0d_exec_rsp", k), rsp_valid, 0);
            @(negedge clk);
        end
        #1;
        chk("tie_last_rsp_valid", rsp_valid, 1);
        chk("tie_last_rsp_id", rsp_id, 1);
        chk("tie_last_rsp_result", rsp_result, 16'h0000);
        m_sel = 5'b00011; m_a = 16'd5; m_b = 16'd8;
        fr = alu_f(5'b00011, 16'd5, 16'd8);
        m_status = fr[20:16];
        chk("tie_status", status, m_status);

        // Reset while an operation is in EXEC drops it
        @(negedge clk);
        drive_req(0, 1'b1, 5'b00000, 16'd1, 16'd2);
        @(negedge clk);
        drive_req(0, 1'b0, 5'b00000, 16'd1, 16'd2);
        #1 chk("inflight_busy", busy, 1);
        #1 rst = 1'b1;
        #1;
        chk("inflight_rst_status", status, 0);
        chk("inflight_rst_rsp", rsp_valid, 0);
        chk("inflight_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("inflight_no_rsp", rsp_valid, 0);
        chk("inflight_status", status, 0);
        m_sel = '0; m_a = '0; m_b = '0; m_status = '0;
        run_op("after_rst", 1, 5'b00000, 16'd100, 16'd23, 16'd123, 1'b1);

        // Randomized traffic against a transaction-level model
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_status = '0;
        mbusy = 1'b0; m_last = 1'b1; e_v = 1'b0;
        e_id = 1'b0; e_wb = 1'b0; e_err = 1'b0; e_flags = '0; e_res = '0;
        ps = '0; pa = '0; pb = '0; own = 0;
        for (int k = 0; k < 2; k++) begin
            mv[k] = 1'b0; qs[k] = '0; qa[k] = '0; qb[k] = '0;
        end
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (cyc != 0) @(negedge clk);
            #1;
            chk("rnd_rsp_valid", rsp_valid, e_v);
            if (e_v && rsp_valid) begin
                chk("rnd_rsp_id", rsp_id, e_id);
                chk("rnd_rsp_result", rsp_result, e_res);
                chk("rnd_rsp_flags", rsp_flags, e_flags);
                chk("rnd_rsp_wb", rsp_wb, e_wb);
                chk("rnd_rsp_err", rsp_err, e_err);
            end
            chk("rnd_busy", busy, mbusy);
            chk("rnd_status", status, m_status);

            for (int k = 0; k < 2; k++) begin
                if (mv[k]) begin
                    if ($urandom_range(0, 7) == 0) mv[k] = 1'b0;
                end else if ($urandom_range(0, 2) != 0) begin
                    mv[k] = 1'b1;
                    if ($urandom_range(0, 7) == 0) qs[k] = 5'($urandom_range(0, 31));
                    else qs[k] = legal_ops[$urandom_range(0, 7)];
                    qa[k] = 16'($urandom);
                    qb[k] = ($urandom_range(0, 3) == 0) ? qa[k] : 16'($urandom);
                end
                drive_req(k, mv[k], qs[k], qa[k], qb[k]);
            end
            #1;

            g0 = 1'b0; g1 = 1'b0;
            if (!mbusy) begin
                if (mv[0] && mv[1]) begin
                    g0 = m_last; g1 = !m_last;
                end else begin
                    g0 = mv[0]; g1 = mv[1];
                end
            end
            chk("rnd_req0_ready", req0_ready, g0);
            chk("rnd_req1_ready", req1_ready, g1);

            e_v = 1'b0;
            if (mbusy) begin
                fr      = alu_f(ps, pa, pb);
                ill     = CHK && !is_legal(ps);
                e_v     = 1'b1;
                e_id    = own[0];
                e_err   = ill;
                e_res   = ill ? 16'h0 : fr[15:0];
                e_flags = ill ? 5'h0 : fr[20:16];
                e_wb    = ill ? 1'b0 : is_wb(ps);
                if (!ill) m_status = fr[20:16];
                mbusy = 1'b0;
            end else if (g0 || g1) begin
                own    = g1 ? 1 : 0;
                ps     = qs[own]; pa = qa[own]; pb = qb[own];
                m_last = g1;
                mv[own] = 1'b0;
                mbusy  = 1'b1;
            end
        end
        @(negedge clk);
        drive_req(0, 1'b0, 5'b0, 16'd0, 16'd0);
        drive_req(1, 1'b0, 5'b0, 16'd0, 16'd0);
        #1;
        chk("rnd_final_rsp_valid", rsp_valid, e_v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
